// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and the stage registers it drives.
// Control words are packed as {pc_en, four stage enables, four stage flushes}.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Bubble contents loaded by any stage register whose flush is asserted.
    localparam logic [31:0] BUBBLE_IR   = 32'd0;
    localparam logic [15:0] BUBBLE_CTRL = 16'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    // Every flush is paired with its enable so a bubble is actually loaded.
    localparam pipe_ctrl_t CTRL_FREEZE   = pipe_ctrl_t'(9'b0_0000_0000);
    localparam pipe_ctrl_t CTRL_INIT     = pipe_ctrl_t'(9'b0_1111_1111);
    localparam pipe_ctrl_t CTRL_RUN      = pipe_ctrl_t'(9'b1_1111_0000);
    localparam pipe_ctrl_t CTRL_REDIRECT = pipe_ctrl_t'(9'b1_1111_1100);
    localparam pipe_ctrl_t CTRL_LOAD_USE = pipe_ctrl_t'(9'b0_0111_0100);

    // Redirect wins over load-use: the dependent instruction is squashed anyway.
    function automatic pipe_ctrl_t resolve_hazard(input logic redirect, input logic load_use);
        pipe_ctrl_t c;
        if (redirect) begin
            c = CTRL_REDIRECT;
        end else if (load_use) begin
            c = CTRL_LOAD_USE;
        end else begin
            c = CTRL_RUN;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator between the load in EX and the instruction in ID.
// Register zero never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = (ex_rd == id_rs);
    assign rt_hit_s = id_uses_rt & (ex_rd == id_rt);
    assign load_use = ex_mem_read & (ex_rd != REG_ZERO) & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage core: post-reset bubbling, hazard stalls/flushes,
// data-memory freeze and fatal memory timeout. Control outputs are Mealy.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [1:0]       state
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  STALL_MAX = {CNT_W{1'b1}};

    pipe_state_e       state_r;
    pipe_state_e       next_state_s;
    logic [INIT_W-1:0] init_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              halted_r;
    logic              load_use_s;
    logic              mem_stall_s;
    logic              stall_inc_s;
    pipe_ctrl_t        ctrl_s;

    hazard_detect u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use_s)
    );

    assign mem_stall_s = mem_req & ~mem_ready;

    // Next-state and control-word selection from current state and inputs.
    always_comb begin
        ctrl_s       = CTRL_FREEZE;
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                ctrl_s = CTRL_INIT;
                if (init_cnt_r == INIT_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (mem_stall_s) begin
                    ctrl_s       = CTRL_FREEZE;
                    next_state_s = ST_MEM_WAIT;
                end else begin
                    ctrl_s       = resolve_hazard(ex_redirect, load_use_s);
                    next_state_s = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    ctrl_s       = resolve_hazard(ex_redirect, load_use_s);
                    next_state_s = ST_RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    ctrl_s       = CTRL_FREEZE;
                    next_state_s = ST_HALT;
                end else begin
                    ctrl_s       = CTRL_FREEZE;
                    next_state_s = ST_MEM_WAIT;
                end
            end
            ST_HALT: begin
                ctrl_s       = CTRL_FREEZE;
                next_state_s = ST_HALT;
            end
            default: begin
                ctrl_s       = CTRL_FREEZE;
                next_state_s = ST_INIT;
            end
        endcase
    end

    // Sequencer state, init/wait counters and sticky halt flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_INIT;
            init_cnt_r <= '0;
            wait_cnt_r <= '0;
            halted_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_INIT: begin
                    init_cnt_r <= init_cnt_r + 1'b1;
                    wait_cnt_r <= '0;
                end
                ST_RUN: begin
                    init_cnt_r <= '0;
                    wait_cnt_r <= mem_stall_s ? WAIT_ONE : '0;
                end
                ST_MEM_WAIT: begin
                    init_cnt_r <= '0;
                    wait_cnt_r <= mem_ready ? '0 : wait_cnt_r + 1'b1;
                end
                ST_HALT: begin
                    init_cnt_r <= '0;
                    wait_cnt_r <= '0;
                end
                default: begin
                    init_cnt_r <= '0;
                    wait_cnt_r <= '0;
                end
            endcase
            if (next_state_s == ST_HALT) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
        end
    end

    // Only live pipeline states count PC stalls; INIT and HALT are excluded.
    assign stall_inc_s = ((state_r == ST_RUN) || (state_r == ST_MEM_WAIT)) && !ctrl_s.pc_en;

    // Saturating PC-stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
        end else if (stall_inc_s && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + 1'b1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign pc_en        = ctrl_s.pc_en;
    assign if_id_en     = ctrl_s.if_id_en;
    assign id_ex_en     = ctrl_s.id_ex_en;
    assign ex_mem_en    = ctrl_s.ex_mem_en;
    assign mem_wb_en    = ctrl_s.mem_wb_en;
    assign if_id_flush  = ctrl_s.if_id_flush;
    assign id_ex_flush  = ctrl_s.id_ex_flush;
    assign ex_mem_flush = ctrl_s.ex_mem_flush;
    assign mem_wb_flush = ctrl_s.mem_wb_flush;
    assign halted       = halted_r;
    assign stall_count  = stall_cnt_r;
    assign state        = state_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner sequences and
// randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 4;
    localparam int SAT         = (1 << CNT_W) - 1;

    localparam logic [8:0] V_INIT  = 9'b0_1111_1111;
    localparam logic [8:0] V_FRZ   = 9'b0_0000_0000;
    localparam logic [8:0] V_RUN   = 9'b1_1111_0000;
    localparam logic [8:0] V_REDIR = 9'b1_1111_1100;
    localparam logic [8:0] V_LU    = 9'b0_0111_0100;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [4:0]       id_rs = 5'd0, id_rt = 5'd0, ex_rd = 5'd0;
    logic             id_uses_rt = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
    logic             mem_req = 1'b0, mem_ready = 1'b0;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_count;
    logic [1:0]       state;
    logic [8:0]       out_vec;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=init, 1=run, 2=memory wait, 3=halt
    int m_mode, m_init_done, m_miss, m_stalls, m_halted;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .mem_wb_flush (mem_wb_flush),
        .halted       (halted),
        .stall_count  (stall_count),
        .state        (state)
    );

    assign out_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                      if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       uses_rt, mread, redir, req, rdy;
        logic [8:0] exp;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] model_out();
        bit dep;
        dep = ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        if (m_mode == 0) return V_INIT;
        if (m_mode == 3) return V_FRZ;
        if (m_mode == 1 && mem_req && !mem_ready) return V_FRZ;
        if (m_mode == 2 && !mem_ready) return V_FRZ;
        if (ex_redirect) return V_REDIR;
        if (dep) return V_LU;
        return V_RUN;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_init_done = 0; m_miss = 0; m_stalls = 0; m_halted = 0;
    endtask

    task automatic model_update(input logic [8:0] o);
        if ((m_mode == 1 || m_mode == 2) && !o[8] && m_stalls < SAT) m_stalls++;
        case (m_mode)
            0: begin
                m_init_done++;
                if (m_init_done == INIT_CYCLES) m_mode = 1;
            end
            1: if (mem_req && !mem_ready) begin m_mode = 2; m_miss = 1; end
            2: if (mem_ready) begin
                   m_mode = 1; m_miss = 0;
               end else begin
                   m_miss++;
                   if (m_miss == MEM_TIMEOUT) begin m_mode = 3; m_halted = 1; end
               end
            default: ;
        endcase
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic mread, input logic [4:0] rd, input logic redir,
                          input logic req, input logic rdy);
        id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mread;
        ex_rd = rd; ex_redirect = redir; mem_req = req; mem_ready = rdy;
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic tick(input logic has_exp, input logic [8:0] exp);
        logic [8:0] mo;
        @(negedge clk);
        mo = model_out();
        check("outputs", 32'(out_vec), 32'(mo));
        check("state", 32'(state), 32'(m_mode));
        check("halted", 32'(halted), 32'(m_halted));
        check("stall_count", 32'(stall_count), 32'(m_stalls));
        if (has_exp) check("vector", 32'(out_vec), 32'(exp));
        model_update(mo);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_outputs", 32'(out_vec), 32'(V_INIT));
        check("rst_stall_count", 32'(stall_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl[9];
        int sc;
        tbl[0] = '{rs:5'd8, rt:5'd0, rd:5'd8, uses_rt:1'b0, mread:1'b1, redir:1'b0, req:1'b0, rdy:1'b0, exp:V_LU};
        tbl[1] = '{rs:5'd0, rt:5'd0, rd:5'd0, uses_rt:1'b0, mread:1'b1, redir:1'b0, req:1'b0, rdy:1'b0, exp:V_RUN};
        tbl[2] = '{rs:5'd8, rt:5'd0, rd:5'd8, uses_rt:1'b0, mread:1'b1, redir:1'b1, req:1'b0, rdy:1'b0, exp:V_REDIR};
        tbl[3] = '{rs:5'd3, rt:5'd9, rd:5'd9, uses_rt:1'b1, mread:1'b1, redir:1'b0, req:1'b0, rdy:1'b0, exp:V_LU};
        tbl[4] = '{rs:5'd3, rt:5'd9, rd:5'd9, uses_rt:1'b0, mread:1'b1, redir:1'b0, req:1'b0, rdy:1'b0, exp:V_RUN};
        tbl[5] = '{rs:5'd8, rt:5'd0, rd:5'd8, uses_rt:1'b0, mread:1'b0, redir:1'b0, req:1'b0, rdy:1'b0, exp:V_RUN};
        tbl[6] = '{rs:5'd1, rt:5'd2, rd:5'd7, uses_rt:1'b1, mread:1'b0, redir:1'b0, req:1'b1, rdy:1'b1, exp:V_RUN};
        tbl[7] = '{rs:5'd1, rt:5'd2, rd:5'd7, uses_rt:1'b1, mread:1'b0, redir:1'b1, req:1'b0, rdy:1'b0, exp:V_REDIR};
        tbl[8] = '{rs:5'd5, rt:5'd2, rd:5'd5, uses_rt:1'b0, mread:1'b1, redir:1'b0, req:1'b1, rdy:1'b1, exp:V_LU};

        // Reset then idle: four bubble cycles, then RUN
        apply_reset();
        for (int i = 0; i < INIT_CYCLES; i++) tick(1'b1, V_INIT);
        check("run_state", 32'(state), 32'd1);
        tick(1'b1, V_RUN);

        // Decode table in RUN
        for (int i = 0; i < 9; i++) begin
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].mread, tbl[i].rd,
                   tbl[i].redir, tbl[i].req, tbl[i].rdy);
            tick(1'b1, tbl[i].exp);
        end
        check("table_stalls", 32'(stall_count), 32'd3);

        // Memory wait: three not-ready cycles then release
        sc = int'(stall_count);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, V_FRZ);
        check("wait_state", 32'(state), 32'd2);
        mem_ready = 1'b1;
        tick(1'b1, V_RUN);
        check("wait_stalls", 32'(stall_count), 32'(sc + 3));

        // Redirect held under a frozen MEM is honoured when ready arrives
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, V_FRZ);
        mem_ready = 1'b1;
        tick(1'b1, V_REDIR);

        // Timeout into HALT, then async reset out of it
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) tick(1'b1, V_FRZ);
        check("halt_state", 32'(state), 32'd3);
        check("halt_flag", 32'(halted), 32'd1);
        mem_ready = 1'b1;
        tick(1'b1, V_FRZ);
        tick(1'b1, V_FRZ);
        apply_reset();
        for (int i = 0; i < INIT_CYCLES; i++) tick(1'b1, V_INIT);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, V_RUN);

        // Saturation after 20 load-use stalls
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, V_LU);
        check("saturation", 32'(stall_count), 32'(SAT));

        // Randomized traffic against the model, with periodic resets
        for (int n = 0; n < 600; n++) begin
            if (n % 120 == 0) apply_reset();
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) < 6));
            tick(1'b0, V_FRZ);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 5-stage core. Drives the load-enable and flush inputs of the PC and the four inter-stage registers, including MEM_WB_register.
- **Post-reset clear:** after reset it bubbles every stage.
- **Hazards and memory:** it resolves load-use hazards and branch/jump redirects, and freezes the whole pipeline while data memory is not ready.
- **Fatal timeout:** a memory timeout halts the core.

## Interface
Parameters:
- INIT_CYCLES, 4: cycles of forced bubbles after reset (covers IF_ID, ID_EX, EX_MEM, MEM_WB).
- MEM_TIMEOUT, 64: maximum consecutive not-ready cycles before HALT; must be ≥2.
- CNT_W, 16: width of stall counter.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of EX instruction
- ex_redirect  in  1  branch taken or jump resolved in EX
- mem_req  in  1  MEM stage performs a data-memory access
- mem_ready  in  1  data memory completes access this cycle
- pc_en  out  1  PC load enable
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble: all control flags 0, IR 0
- halted  out  1  sticky memory-timeout indication
- stall_count  out  CNT_W  saturating count of PC-stall cycles
- state  out  2  current FSM state (debug)

## Operation
- **States:** INIT=0, RUN=1, MEM_WAIT=2, HALT=3.
- **Encoding rule:** flush=1 always implies the matching en=1.
- **Load-use condition:** load_use = ex_mem_read & ex_rd≠0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- **freeze outputs:** all en=0, all flush=0.
- **INIT:**
  - Outputs: pc_en=0, all stage en=1, all flush=1.
  - init_cnt increments each cycle; after INIT_CYCLES cycles go to RUN.
  - All inputs are ignored.
- **RUN:** the first matching case in this priority order applies.
  1. mem_req & !mem_ready: freeze outputs; next state MEM_WAIT, wait_cnt=1.
  2. ex_redirect: all en=1, if_id_flush=1, id_ex_flush=1. Redirect beats load_use.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1 (id_ex_en=1), ex_mem_en=mem_wb_en=1.
  4. Otherwise: all en=1, no flush.
- **MEM_WAIT:**
  - If mem_ready: apply RUN cases 2–4 with the current inputs and go to RUN; wait_cnt=0.
  - Otherwise: freeze outputs and increment wait_cnt. When wait_cnt+1==MEM_TIMEOUT, go to HALT.
- **HALT:**
  - Outputs: all en=0, no flush, halted=1.
  - Only reset exits HALT.
- **stall_count:**
  - +1 on each RUN/MEM_WAIT cycle with pc_en=0.
  - Saturates at 2^CNT_W−1.
  - Not counted in INIT or HALT.

## Timing
- Outputs are combinational from state and inputs (Mealy). Stage registers act on the next rising edge.
- **Reset asserted (async):**
  - state=INIT, init_cnt=0, wait_cnt=0, stall_count=0, halted=0.
  - Outputs immediately take INIT values: pc_en=0, stage en=1, flush=1.
- **Reset mid-operation:** any state, including HALT, returns to INIT and redoes the full INIT_CYCLES bubble sequence.
- **Load-use:** costs exactly 1 cycle. The next cycle the load is in MEM, so load_use is false.
- **Redirect:** costs 2 bubbles (IF_ID, ID_EX). The PC loads the target on the same edge.
- **Redirect with frozen MEM:** redirect is ignored while mem_req & !mem_ready. Frozen registers keep ex_redirect stable, so it is honoured in the cycle mem_ready arrives.
- **Single-cycle access:** mem_req & mem_ready in the same RUN cycle causes no stall.
- **Timeout:** HALT is entered after exactly MEM_TIMEOUT consecutive not-ready cycles.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (INIT/RUN/MEM_WAIT/HALT);
  - REG_ZERO=5'd0;
  - bubble constants reused by all stage registers.
- Sub-module hazard_detect: purely combinational load_use comparator, reused later by the forwarding unit.
- The top holds the FSM, init/wait counters, stall counter and output muxing.

## Test plan
- **Reset then idle:** assert reset for 2 cycles, then release.
  - 4 cycles: pc_en=0, all flush=1.
  - Cycle 5: state=RUN, all en=1, stall_count=0.
- **Load-use:** ex_mem_read=1, ex_rd=8, id_rs=8.
  - One cycle of pc_en=0, if_id_en=0, id_ex_flush=1.
  - stall_count 0→1.
  - ex_rd=0 with same stimulus: no stall.
- **Redirect + load-use in the same cycle:** ex_redirect=1, load_use true.
  - Outputs: pc_en=1, if_id_flush=1, id_ex_flush=1.
  - stall_count unchanged.
- **Memory wait:** mem_req=1, mem_ready=0 for 3 cycles, then ready.
  - 3 cycles all en=0, state=MEM_WAIT.
  - Release cycle all en=1.
  - stall_count +3.
- **Timeout:** MEM_TIMEOUT=8, mem_ready held 0.
  - After 8 not-ready cycles: state=HALT, halted=1.
  - Enables stay 0 when mem_ready later rises.
  - Async reset mid-HALT: halted=0 immediately, INIT sequence replays.
- **Saturation:** CNT_W=4, 20 load-use stalls → stall_count=15.
